// File: rtl/conv_sequencer.sv
// Control FSM for the convolution engine: fills the x/f memories, sweeps the MAC taps, hands out y.
// Build option: define CONV_SEQ_KEEP_F_EN to keep the loaded filter across runs until reset.
module conv_sequencer #(
    parameter int LEN_X  = 8,
    parameter int LEN_F  = 4,
    parameter int ADDR_X = 3,
    parameter int ADDR_F = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid_x,
    output logic              s_ready_x,
    input  logic              s_valid_f,
    output logic              s_ready_f,
    output logic              m_valid_y,
    input  logic              m_ready_y,
    output logic [ADDR_X-1:0] addr_x,
    output logic [ADDR_F-1:0] addr_f,
    output logic              wr_en_x,
    output logic              wr_en_f,
    output logic              clr_acc,
    output logic              en_acc
);

    localparam int CW_X = $clog2(LEN_X + 1);
    localparam int CW_F = $clog2(LEN_F + 1);

    localparam logic [CW_X-1:0]   X_FULL = CW_X'(LEN_X);
    localparam logic [CW_F-1:0]   F_FULL = CW_F'(LEN_F);
    localparam logic [ADDR_X-1:0] J_LAST = ADDR_X'(LEN_X - LEN_F);
    localparam logic [ADDR_F-1:0] K_LAST = ADDR_F'(LEN_F - 1);

    typedef enum logic [2:0] {
        LOAD,
        CLR,
        MAC,
        WAIT,
        OUT
    } state_t;

    state_t            state, state_nx;
    logic [CW_X-1:0]   cnt_x, cnt_x_nx;
    logic [CW_F-1:0]   cnt_f, cnt_f_nx;
    logic [ADDR_X-1:0] j, j_nx;
    logic [ADDR_F-1:0] k, k_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
            cnt_x <= '0;
            cnt_f <= '0;
            j     <= '0;
            k     <= '0;
        end else begin
            state <= state_nx;
            cnt_x <= cnt_x_nx;
            cnt_f <= cnt_f_nx;
            j     <= j_nx;
            k     <= k_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_x_nx  = cnt_x;
        cnt_f_nx  = cnt_f;
        j_nx      = j;
        k_nx      = k;
        s_ready_x = 1'b0;
        s_ready_f = 1'b0;
        m_valid_y = 1'b0;
        addr_x    = '0;
        addr_f    = '0;
        wr_en_x   = 1'b0;
        wr_en_f   = 1'b0;
        clr_acc   = 1'b0;
        en_acc    = 1'b0;

        case (state)
            LOAD: begin
                // Ready is forced low while reset is held so no beat is taken during reset.
                s_ready_x = ~reset & (cnt_x < X_FULL);
                s_ready_f = ~reset & (cnt_f < F_FULL);
                wr_en_x   = s_valid_x & s_ready_x;
                wr_en_f   = s_valid_f & s_ready_f;
                addr_x    = ADDR_X'(cnt_x);
                addr_f    = ADDR_F'(cnt_f);
                if (wr_en_x) cnt_x_nx = cnt_x + CW_X'(1);
                if (wr_en_f) cnt_f_nx = cnt_f + CW_F'(1);
                // Decide on the post-edge counts so the final beat(s) lead straight into CLR.
                if ((cnt_x_nx == X_FULL) && (cnt_f_nx == F_FULL)) state_nx = CLR;
            end
            CLR: begin
                clr_acc  = 1'b1;
                k_nx     = '0;
                state_nx = MAC;
            end
            MAC: begin
                addr_x = j + ADDR_X'(k);
                addr_f = k;
                en_acc = (k != '0);
                k_nx   = k + ADDR_F'(1);
                if (k == K_LAST) state_nx = WAIT;
            end
            WAIT: begin
                en_acc   = 1'b1;
                state_nx = OUT;
            end
            OUT: begin
                m_valid_y = 1'b1;
                if (m_ready_y) begin
                    if (j == J_LAST) begin
                        j_nx     = '0;
                        cnt_x_nx = '0;
`ifdef CONV_SEQ_KEEP_F_EN
                        cnt_f_nx = cnt_f;
`else
                        cnt_f_nx = '0;
`endif
                        state_nx = LOAD;
                    end else begin
                        j_nx     = j + ADDR_X'(1);
                        state_nx = CLR;
                    end
                end
            end
            default: state_nx = LOAD;
        endcase
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: models the two registered-read memories and the MAC accumulator.
module tb_conv_sequencer;

    localparam int LEN_X  = 8;
    localparam int LEN_F  = 4;
    localparam int ADDR_X = 3;
    localparam int ADDR_F = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              s_valid_x = 1'b0, s_valid_f = 1'b0;
    logic              s_ready_x, s_ready_f;
    logic              m_valid_y;
    logic              m_ready_y = 1'b0;
    logic [ADDR_X-1:0] addr_x;
    logic [ADDR_F-1:0] addr_f;
    logic              wr_en_x, wr_en_f, clr_acc, en_acc;

    conv_sequencer #(.LEN_X(LEN_X), .LEN_F(LEN_F), .ADDR_X(ADDR_X), .ADDR_F(ADDR_F)) dut (
        .clk(clk), .reset(reset),
        .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
        .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
        .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
        .addr_x(addr_x), .addr_f(addr_f),
        .wr_en_x(wr_en_x), .wr_en_f(wr_en_f),
        .clr_acc(clr_acc), .en_acc(en_acc)
    );

    always #5 clk = ~clk;

    // Datapath model: registered-read memories and accumulator driven by the DUT strobes.
    logic signed [15:0] x_data = '0, f_data = '0;
    logic signed [15:0] mem_x [LEN_X];
    logic signed [15:0] mem_f [LEN_F];
    logic signed [15:0] rd_x, rd_f;
    logic signed [31:0] acc;
    int                 cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en_x) mem_x[addr_x] <= x_data;
        if (wr_en_f) mem_f[addr_f] <= f_data;
        rd_x <= mem_x[addr_x];
        rd_f <= mem_f[addr_f];
        if (clr_acc) acc <= '0;
        else if (en_acc) acc <= acc + rd_x * rd_f;
    end

    int checks = 0, errors = 0;
    int q[$];
    int out_cyc[$];
    int out_cnt = 0;
    int rmode = 0;
    int vmode = 0;
    int last_beat_cyc = 0, first_valid_cyc = 0;
    bit seen_first = 0;
    logic signed [15:0] xv [LEN_X];
    logic signed [15:0] fv [LEN_F];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, {17'd0, m_valid_y, clr_acc, en_acc, wr_en_x, wr_en_f, addr_x, addr_f,
                     s_ready_x, s_ready_f}, 32'd0);
    endtask

    // Ready driver: 0 = always ready, 1 = random, 2 = test drives it.
    initial forever begin
        @(negedge clk);
        if (rmode == 0) m_ready_y = 1'b1;
        else if (rmode == 1) m_ready_y = 1'($urandom_range(0, 1));
    end

    // Monitor: pops the scoreboard on every y handshake.
    bit prev_valid = 0, prev_hs = 0;
    initial forever begin
        @(negedge clk);
        #2;
        if (reset) begin
            prev_valid = 0;
            prev_hs    = 0;
        end else begin
            if (prev_valid && !prev_hs) check("valid_hold", {31'd0, m_valid_y}, 32'd1);
            if (m_valid_y) begin
                check("ready_in_out", {30'd0, s_ready_x, s_ready_f}, 32'd0);
                if (!seen_first) begin
                    seen_first      = 1;
                    first_valid_cyc = cyc;
                end
            end
            if (m_valid_y && m_ready_y) begin
                out_cnt++;
                out_cyc.push_back(cyc);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_y: got %0d required no output", acc);
                end else begin
                    check("y", acc, q.pop_front());
                end
            end
            prev_valid = m_valid_y;
            prev_hs    = m_valid_y && m_ready_y;
        end
    end

    task automatic feed_x();
        int i = 0;
        int g = 0;
        while (i < LEN_X && g < 2000) begin
            @(negedge clk);
            x_data    = xv[i];
            s_valid_x = (vmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (s_valid_x && s_ready_x) begin
                i++;
                last_beat_cyc = cyc;
            end
            g++;
        end
        check("feed_x_done", i, LEN_X);
        @(negedge clk);
        s_valid_x = 1'b0;
    endtask

    task automatic feed_f();
        int i = 0;
        int g = 0;
        while (i < LEN_F && g < 2000) begin
            @(negedge clk);
            f_data    = fv[i];
            s_valid_f = (vmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (s_valid_f && s_ready_f) begin
                i++;
                last_beat_cyc = cyc;
            end
            g++;
        end
        check("feed_f_done", i, LEN_F);
        @(negedge clk);
        s_valid_f = 1'b0;
    endtask

    task automatic wait_outputs();
        int g = 0;
        while (q.size() > 0 && g < 800) begin
            @(negedge clk);
            g++;
        end
        check("outputs_pending", q.size(), 0);
        q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        s_valid_x = 1'b0;
        s_valid_f = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle("reset_outputs");
        repeat (2) @(negedge clk);
        q.delete();
        out_cyc.delete();
        out_cnt    = 0;
        seen_first = 0;
        reset      = 1'b0;
        #1;
        check("ready_after_reset", {30'd0, s_ready_x, s_ready_f}, 32'd3);
        check_idle_but_ready();
    endtask

    task automatic check_idle_but_ready();
        check("idle_after_reset", {22'd0, m_valid_y, clr_acc, en_acc, wr_en_x, wr_en_f, addr_x, addr_f}, 32'd0);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < LEN_X; i++) xv[i] = 16'(i + 1);
        for (int i = 0; i < LEN_F; i++) fv[i] = 16'sd1;
        q.push_back(10); q.push_back(14); q.push_back(18); q.push_back(22); q.push_back(26);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        logic signed [31:0] held;

        // Test 1: ramp x, unit f, everything ready.
        rmode = 0; vmode = 0;
        do_reset();
        load_ramp();
        fork feed_x(); feed_f(); join
        wait_outputs();
        check("latency_last_beat_to_valid", first_valid_cyc - last_beat_cyc, 7);
        check("output_period", (out_cyc.size() >= 2) ? out_cyc[1] - out_cyc[0] : -1, LEN_F + 3);
        check("out_count_t1", out_cnt, 5);
`ifdef CONV_SEQ_KEEP_F_EN
        // Second run reuses the stored filter; f side must stay closed.
        check("ready_f_kept_full", {31'd0, s_ready_f}, 32'd0);
        for (int i = 0; i < LEN_X; i++) xv[i] = 16'(11 * (i + 1));
        q.push_back(110); q.push_back(154); q.push_back(198); q.push_back(242); q.push_back(286);
        s_valid_f = 1'b1;
        f_data    = 16'sd999;
        fork
            feed_x();
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                #1;
                check("keep_f_ready_wr", {30'd0, s_ready_f, wr_en_f}, 32'd0);
            end
        join
        wait_outputs();
        s_valid_f = 1'b0;
`else
        check("ready_after_run", {30'd0, s_ready_x, s_ready_f}, 32'd3);
`endif

        // Test 2: signed data, random valid/ready.
        do_reset();
        xv = '{16'sd10, -16'sd20, 16'sd30, -16'sd40, 16'sd50, 16'sd60, 16'sd70, 16'sd80};
        fv = '{16'sd10, 16'sd20, -16'sd30, 16'sd40};
        q.push_back(-2800); q.push_back(3600); q.push_back(400); q.push_back(1600); q.push_back(2800);
        vmode = 1; rmode = 1;
        fork feed_x(); feed_f(); join
        wait_outputs();
        rmode = 0; vmode = 0;
        repeat (100) @(negedge clk);
        check("out_count_t2", out_cnt, 5);

        // Test 3: f completes 20 cycles before x; extra f beats are offered and must be ignored.
        do_reset();
        load_ramp();
        feed_f();
        s_valid_f = 1'b1;
        f_data    = 16'sd999;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            check("f_full_ready_wr", {30'd0, s_ready_f, wr_en_f}, 32'd0);
        end
        feed_x();
        wait_outputs();
        s_valid_f = 1'b0;

        // Test 4: stall the first output for 10 cycles.
        do_reset();
        load_ramp();
        rmode     = 2;
        m_ready_y = 1'b0;
        fork feed_x(); feed_f(); join
        g = 0;
        while (!m_valid_y && g < 100) begin
            @(negedge clk);
            #3;
            g++;
        end
        check("stall_valid_seen", {31'd0, m_valid_y}, 32'd1);
        held = acc;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #3;
            check("stall_valid", {31'd0, m_valid_y}, 32'd1);
            check("stall_data", acc, held);
            check("stall_ready_in", {30'd0, s_ready_x, s_ready_f}, 32'd0);
        end
        rmode = 0;
        wait_outputs();

        // Test 5: reset during MAC, then a clean run.
        do_reset();
        load_ramp();
        q.delete();
        fork feed_x(); feed_f(); join
        g = 0;
        while (!en_acc && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("mac_reached", {31'd0, en_acc}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_idle("async_reset_mid_mac");
        do_reset();
        load_ramp();
        fork feed_x(); feed_f(); join
        wait_outputs();
        check("out_count_t5", out_cnt, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
